// File: rtl/uart_word_tx.sv
// Word-to-byte serializer for uart_tx: sends each WORD_WIDTH word least-significant byte first
// over the start_n/ready_to_send handshake, with a one-word pending buffer for the producer.
module uart_word_tx #(
  parameter int WORD_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] word,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              tx_data,
  output logic                    tx_start_n,
  input  logic                    tx_ready_to_send
);

  localparam int WORD_WIDTH = 8 * WORD_BYTES;
  localparam int IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    ACCEPT,
    SENDING
  } state_t;

  state_t                 state, state_nx;
  logic [WORD_WIDTH-1:0]  cur, cur_nx;
  logic [WORD_WIDTH-1:0]  pend, pend_nx;
  logic                   pend_full, pend_full_nx;
  logic [IDX_W-1:0]       byte_idx, byte_idx_nx;
  logic                   done_nx;
  logic                   tx_start_n_nx;
  logic [7:0]             tx_data_nx;
  logic                   accept;
  logic                   take_pend;

  assign word_ready = !pend_full;
  assign busy       = (state != IDLE);
  assign accept     = word_valid && !pend_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur        <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      byte_idx   <= '0;
      done       <= 1'b0;
      tx_start_n <= 1'b1;
      tx_data    <= 8'h00;
    end else begin
      state      <= state_nx;
      cur        <= cur_nx;
      pend       <= pend_nx;
      pend_full  <= pend_full_nx;
      byte_idx   <= byte_idx_nx;
      done       <= done_nx;
      tx_start_n <= tx_start_n_nx;
      tx_data    <= tx_data_nx;
    end
  end

  // tx_data only changes together with the start pulse, so it is stable for the whole byte.
  always_comb begin
    state_nx      = state;
    cur_nx        = cur;
    pend_nx       = pend;
    byte_idx_nx   = byte_idx;
    done_nx       = 1'b0;
    tx_start_n_nx = 1'b1;
    tx_data_nx    = tx_data;
    take_pend     = 1'b0;

    case (state)
      IDLE: begin
        if (pend_full) begin
          cur_nx      = pend;
          byte_idx_nx = '0;
          take_pend   = 1'b1;
          state_nx    = START;
        end
      end
      START: begin
        if (tx_ready_to_send) begin
          tx_data_nx    = cur[7:0];
          tx_start_n_nx = 1'b0;
          state_nx      = ACCEPT;
        end
      end
      ACCEPT: begin
        // uart_tx may stay ready for a while after the pulse; wait until it has really taken the byte.
        if (!tx_ready_to_send) begin
          state_nx = SENDING;
        end
      end
      SENDING: begin
        if (tx_ready_to_send) begin
          if (byte_idx != LAST_IDX) begin
            cur_nx      = cur >> 8;
            byte_idx_nx = byte_idx + 1'b1;
            state_nx    = START;
          end else begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (accept) begin
      pend_nx      = word;
      pend_full_nx = 1'b1;
    end else if (take_pend) begin
      pend_full_nx = 1'b0;
    end else begin
      pend_full_nx = pend_full;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: a behavioural uart_tx responder plus a byte-queue
// reference model built from the words handed to the DUT.
module tb_uart_word_tx;

  localparam int WB = 2;
  localparam int WW = 8 * WB;

  logic          clk;
  logic          rst;
  logic [WW-1:0] word;
  logic          word_valid;
  logic          word_ready;
  logic          busy;
  logic          done;
  logic [7:0]    tx_data;
  logic          tx_start_n;
  logic          tx_ready_to_send;

  uart_word_tx #(.WORD_BYTES(WB)) dut (
    .clk              (clk),
    .rst              (rst),
    .word             (word),
    .word_valid       (word_valid),
    .word_ready       (word_ready),
    .busy             (busy),
    .done             (done),
    .tx_data          (tx_data),
    .tx_start_n       (tx_start_n),
    .tx_ready_to_send (tx_ready_to_send)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  int         model_state;
  int         model_cnt;
  logic [7:0] cur_byte;
  int         acc_min, acc_max, send_min, send_max;
  bit         force_low;
  int         starts_seen;
  int         done_count;
  int         bytes_done;
  int         words_sent;
  logic       prev_start_n;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock of the uart_tx responder: sample the DUT, check it, then advance the responder.
  task automatic tick();
    logic [7:0] exp_byte;
    @(negedge clk);
    if (tx_start_n === 1'b0) begin
      starts_seen++;
      checkOutput("start_single_cycle", prev_start_n, 1);
      checkOutput("start_while_tx_idle", model_state, 0);
      checkOutput("start_when_ready", tx_ready_to_send, 1);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_byte", exp_q.size(), 1);
      end else begin
        exp_byte = exp_q.pop_front();
        checkOutput("tx_data_byte", tx_data, exp_byte);
      end
      cur_byte  = tx_data;
      model_cnt = $urandom_range(acc_max, acc_min);
      if (model_cnt == 0) begin
        tx_ready_to_send = 1'b0;
        model_state      = 2;
        model_cnt        = $urandom_range(send_max, send_min);
      end else begin
        model_state = 1;
      end
    end else begin
      if (model_state != 0) checkOutput("tx_data_stable", tx_data, cur_byte);
      case (model_state)
        1: begin
          model_cnt--;
          if (model_cnt == 0) begin
            tx_ready_to_send = 1'b0;
            model_state      = 2;
            model_cnt        = $urandom_range(send_max, send_min);
          end
        end
        2: begin
          model_cnt--;
          if (model_cnt == 0) begin
            tx_ready_to_send = 1'b1;
            model_state      = 0;
            bytes_done++;
          end
        end
        default: tx_ready_to_send = !force_low;
      endcase
    end
    if (done === 1'b1) begin
      done_count++;
      checkOutput("done_after_last_byte", (done_count <= bytes_done / WB), 1);
    end
    prev_start_n = tx_start_n;
  endtask

  // Present a word and hold word_valid until the DUT can take it.
  task automatic applyStimulus(input logic [WW-1:0] w, input int limit);
    bit accepted;
    accepted   = 1'b0;
    word       = w;
    word_valid = 1'b1;
    for (int i = 0; i < limit && !accepted; i++) begin
      if (word_ready === 1'b1) begin
        accepted = 1'b1;
        words_sent++;
        for (int b = 0; b < WB; b++) exp_q.push_back(w[8*b +: 8]);
      end
      tick();
    end
    word_valid = 1'b0;
    checkOutput("word_accepted", accepted, 1);
  endtask

  task automatic wait_starts(input int target, input int limit, input string tag);
    for (int i = 0; i < limit && starts_seen < target; i++) tick();
    checkOutput(tag, (starts_seen >= target), 1);
  endtask

  task automatic drain(input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && model_state == 0 && busy === 1'b0 && done_count == words_sent) break;
      tick();
    end
    checkOutput({tag, "_done_count"}, done_count, words_sent);
    checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int base;
    checks = 0; errors = 0;
    model_state = 0; model_cnt = 0; cur_byte = 8'h00;
    acc_min = 0; acc_max = 3; send_min = 1; send_max = 6;
    force_low = 1'b0; starts_seen = 0; done_count = 0; bytes_done = 0; words_sent = 0;
    prev_start_n = 1'b1;
    rst = 1'b0; word = '0; word_valid = 1'b0; tx_ready_to_send = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_word_ready", word_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_start_n", tx_start_n, 1);
    checkOutput("reset_tx_data", tx_data, 8'h00);
    rst = 1'b1;
    repeat (2) tick();

    // Single word, LSB first.
    base = starts_seen;
    applyStimulus(16'hCDAB, 10);
    drain(300, "t1");
    checkOutput("t1_start_pulses", starts_seen - base, 2);

    // Queue a second and a third word while the first is in flight.
    applyStimulus(16'h1234, 10);
    applyStimulus(16'h5678, 10);
    checkOutput("t2_ready_low_after_second", word_ready, 0);
    applyStimulus(16'h9ABC, 300);
    checkOutput("t6_ready_low_after_third", word_ready, 0);
    drain(500, "t2");

    // Transmitter held busy: no start pulse until it is released.
    force_low = 1'b1;
    tick();
    base = starts_seen;
    applyStimulus(16'hCDAB, 10);
    repeat (10) tick();
    checkOutput("t3_busy_held", busy, 1);
    checkOutput("t3_no_start", starts_seen - base, 0);
    checkOutput("t3_start_n_high", tx_start_n, 1);
    force_low = 1'b0;
    tx_ready_to_send = 1'b1;
    wait_starts(base + 1, 2, "t3_start_after_release");
    checkOutput("t3_first_byte", tx_data, 8'hAB);
    drain(300, "t3");

    // Transmitter slow to drop ready: still exactly one pulse per byte.
    acc_min = 100; acc_max = 100;
    base = starts_seen;
    applyStimulus(16'h4321, 10);
    wait_starts(base + 1, 10, "t4_first_start");
    repeat (100) tick();
    checkOutput("t4_single_start", starts_seen - base, 1);
    drain(600, "t4");
    acc_min = 0; acc_max = 3;

    // Reset on the start pulse of the second byte.
    base = starts_seen;
    applyStimulus(16'hCDAB, 10);
    wait_starts(base + 2, 200, "t5_second_byte");
    rst = 1'b0;
    #1;
    checkOutput("t5_reset_start_n", tx_start_n, 1);
    checkOutput("t5_reset_busy", busy, 0);
    checkOutput("t5_reset_done", done, 0);
    checkOutput("t5_reset_word_ready", word_ready, 1);
    checkOutput("t5_reset_tx_data", tx_data, 8'h00);
    exp_q.delete();
    model_state = 0; tx_ready_to_send = 1'b1; prev_start_n = 1'b1;
    words_sent = 0; done_count = 0; bytes_done = 0;
    repeat (3) tick();
    checkOutput("t5_no_done_in_reset", done_count, 0);
    rst = 1'b1;
    tick();
    applyStimulus(16'hBEEF, 10);
    drain(300, "t5");

    // Randomized words, gaps and transmitter timing.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(4, 0)) tick();
      applyStimulus(16'($urandom()), 300);
    end
    drain(3000, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
